// File: rtl/bellmanford_result_drain.sv
// -----------------------------------------------------------------------------
// bellmanford_result_drain
//
// Reads the bellmanford Output Memory once the core reports Finish. Each node's
// distance is streamed out over a valid/ready port while the block keeps
// running statistics on the words that get transferred. If the core reports a
// negative cycle, the distance table is meaningless: the block raises NegFlag
// and stops, and no further words are exported.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   Finish, NegCycle    status from the bellmanford core
//   OMAR / OMDR         Output Memory read address / same-cycle read data
//   OutData/OutValid/
//   OutReady/OutLast    distance stream; OutLast marks address NUM_NODES-1
//   NegFlag             a negative cycle was reported
//   Done                drain finished or aborted; held until reset
//   ReachCount          number of transferred words that are not INF
//   MaxDist             largest transferred non-INF word (0 if none)
// -----------------------------------------------------------------------------
module bellmanford_result_drain #(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    NUM_NODES  = 8192,
    parameter logic [DATA_WIDTH-1:0] INF        = '1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  Finish,
    input  logic                  NegCycle,
    output logic [ADDR_WIDTH-1:0] OMAR,
    input  logic [DATA_WIDTH-1:0] OMDR,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  OutLast,
    output logic                  NegFlag,
    output logic                  Done,
    output logic [ADDR_WIDTH:0]   ReachCount,
    output logic [DATA_WIDTH-1:0] MaxDist
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NODES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, next_state;

    // OMAR saturates on the last address, so a separate bit remembers that
    // the last word has already been fetched into the output register.
    logic fetched_all;

    logic xfer;       // word in the output register is accepted this edge
    logic start;      // clean Finish in IDLE: begin streaming
    logic flag_neg;   // negative cycle reported: terminate with NegFlag
    logic load;       // refill the output register from OMDR
    logic drop;       // transfer with no refill empties the register
    logic count_en;   // transferred word contributes to the statistics

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        xfer       = OutValid & OutReady;
        start      = 1'b0;
        flag_neg   = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        count_en   = 1'b0;
        case (state)
            IDLE: begin
                if (Finish) begin
                    if (NegCycle) begin
                        flag_neg   = 1'b1;
                        next_state = DONE;
                    end else begin
                        start      = 1'b1;
                        next_state = STREAM;
                    end
                end
            end
            STREAM: begin
                // An abort beats everything, including a coincident last
                // transfer, so that word is neither counted nor completed.
                if (NegCycle) begin
                    flag_neg   = 1'b1;
                    next_state = DONE;
                end else begin
                    count_en = xfer && (OutData != INF);
                    load     = (!OutValid || xfer) && !fetched_all;
                    drop     = xfer && !load;
                    if (xfer && OutLast) next_state = DONE;
                end
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            OMAR        <= '0;
            fetched_all <= 1'b0;
            OutData     <= '0;
            OutValid    <= 1'b0;
            OutLast     <= 1'b0;
            NegFlag     <= 1'b0;
            Done        <= 1'b0;
            ReachCount  <= '0;
            MaxDist     <= '0;
        end else begin
            if (start) begin
                OMAR        <= '0;
                fetched_all <= 1'b0;
                ReachCount  <= '0;
                MaxDist     <= '0;
            end

            if (flag_neg) begin
                // Any pending word is discarded; statistics freeze as-is.
                OutValid <= 1'b0;
                OutLast  <= 1'b0;
                NegFlag  <= 1'b1;
                Done     <= 1'b1;
            end

            if (count_en) begin
                ReachCount <= ReachCount + (ADDR_WIDTH+1)'(1);
                if (OutData > MaxDist) MaxDist <= OutData;
            end

            if (load) begin
                OutData  <= OMDR;
                OutValid <= 1'b1;
                OutLast  <= (OMAR == LAST_ADDR);
                if (OMAR == LAST_ADDR) fetched_all <= 1'b1;
                else                   OMAR        <= OMAR + ADDR_WIDTH'(1);
            end else if (drop) begin
                // Only the last word can leave without a refill, which
                // also marks the drain as complete.
                OutValid <= 1'b0;
                OutLast  <= 1'b0;
                if (OutLast) Done <= 1'b1;
            end
        end
    end

endmodule
